uart_rx_param: RTL

//   Parametrised UART receiver, successor to the fixed 8-bit parity receiver.

---
 rtl/uart_rx_param_if.sv | 45 ++++
 rtl/uart_rx_param.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param_if.sv
// ---------------------------------------------------------------------------
// uart_rx_param_if
//   Output bundle of the parametrised UART receiver: the received word, its
//   error flags and the valid/ready handshake toward the consumer.
//
//   Signals
//     dout        DATA_W  received data word
//     dout_valid  1       dout/flags hold a word not yet accepted
//     dout_ready  1       consumer accepts the word when high with dout_valid
//     parity_err  1       parity mismatch on the word in dout
//     frame_err   1       a stop bit sampled 0 for the word in dout
//     overrun     1       sticky: a frame was dropped while dout_valid was high
//
//   Modports
//     master  receiver side (drives data, flags, valid; reads ready)
//     slave   consumer side (reads data, flags, valid; drives ready)
// ---------------------------------------------------------------------------
interface uart_rx_param_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] dout;
    logic              dout_valid;
    logic              dout_ready;
    logic              parity_err;
    logic              frame_err;
    logic              overrun;

    modport master (
        output dout,
        output dout_valid,
        output parity_err,
        output frame_err,
        output overrun,
        input  dout_ready
    );

    modport slave (
        input  dout,
        input  dout_valid,
        input  parity_err,
        input  frame_err,
        input  overrun,
        output dout_ready
    );
endinterface

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
//   Parametrised UART receiver. The asynchronous serial input is synchronised,
//   a start bit is qualified at half-bit (short low glitches are rejected),
//   then data, optional parity and stop bits are sampled at mid-bit. The
//   finished word is presented on a valid/ready handshake together with parity
//   and framing error flags; a frame that completes while the previous word is
//   still unaccepted is dropped and flagged by the sticky overrun bit.
//
//   Parameters
//     DATA_W        data bits per frame (5..9), LSB first
//     PARITY        0 = none, 1 = even, 2 = odd
//     STOP_BITS     1 or 2
//     CLKS_PER_BIT  clk cycles per serial bit (>= 4)
//     SYNC_STAGES   rxd synchroniser depth (>= 2)
//
//   Ports
//     clk    in   system clock, rising edge
//     rst    in   asynchronous reset, active-low
//     rxd    in   serial input, idle high, asynchronous to clk
//     busy   out  high whenever the receiver is inside a frame
//     rx_if  master side of uart_rx_param_if (dout, flags, handshake)
// ---------------------------------------------------------------------------
module uart_rx_param #(
    parameter int DATA_W       = 8,
    parameter int PARITY       = 1,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 16,
    parameter int SYNC_STAGES  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rxd,
    output logic             busy,
    uart_rx_param_if.master  rx_if
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATA_W - 1);
    localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 2);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    // Synchroniser: resets to the idle (high) line level
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];

    // Frame FSM state and per-frame working registers
    state_t            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic [IDX_W-1:0]  idx, idx_d;
    logic [DATA_W-1:0] shreg, shreg_d;
    logic              perr, perr_d;
    logic              ferr, ferr_d;
    logic              armed, armed_d;
    logic              done, done_d;
    logic              tick;

    assign tick = (cnt == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            perr  <= 1'b0;
            ferr  <= 1'b0;
            armed <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            idx   <= idx_d;
            shreg <= shreg_d;
            perr  <= perr_d;
            ferr  <= ferr_d;
            armed <= armed_d;
            done  <= done_d;
        end
    end

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        idx_d   = idx;
        shreg_d = shreg;
        perr_d  = perr;
        ferr_d  = ferr;
        armed_d = armed;
        done_d  = 1'b0;

        unique case (state)
            IDLE: begin
                // A frame that ended on a low line (break) must see the line
                // return high before the next falling edge can start a frame.
                if (rxs) begin
                    armed_d = 1'b1;
                end else if (armed) begin
                    state_d = START;
                    cnt_d   = HALF_BIT;
                    idx_d   = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                end
            end
            START: begin
                if (!tick) begin
                    cnt_d = cnt - 1'b1;
                end else if (rxs) begin
                    state_d = IDLE;
                end else begin
                    state_d = DATA;
                    cnt_d   = FULL_BIT;
                end
            end
            DATA: begin
                if (!tick) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    shreg_d = {rxs, shreg[DATA_W-1:1]};
                    cnt_d   = FULL_BIT;
                    if (idx == LAST_DATA) begin
                        idx_d   = '0;
                        state_d = (PARITY != 0) ? PAR : STOP;
                    end else begin
                        idx_d = idx + 1'b1;
                    end
                end
            end
            PAR: begin
                if (!tick) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    // XOR over data+parity is 0 for an even count of ones
                    perr_d  = (^{shreg, rxs}) ^ ODD_PAR;
                    state_d = STOP;
                    cnt_d   = FULL_BIT;
                end
            end
            STOP: begin
                if (!tick) begin
                    cnt_d = cnt - 1'b1;
                end else begin
                    if (!rxs) begin
                        ferr_d = 1'b1;
                    end
                    if (idx == LAST_STOP) begin
                        // Leave mid stop bit so a back-to-back start is caught
                        state_d = IDLE;
                        done_d  = 1'b1;
                        armed_d = rxs;
                    end else begin
                        idx_d = idx + 1'b1;
                        cnt_d = FULL_BIT;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    // Output word and handshake; an accept in the completion cycle frees the
    // slot first, so the new word loads without raising overrun.
    logic accept;

    assign accept = rx_if.dout_valid & rx_if.dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_if.dout       <= '0;
            rx_if.dout_valid <= 1'b0;
            rx_if.parity_err <= 1'b0;
            rx_if.frame_err  <= 1'b0;
            rx_if.overrun    <= 1'b0;
        end else begin
            if (accept) begin
                rx_if.dout_valid <= 1'b0;
                rx_if.overrun    <= 1'b0;
            end
            if (done) begin
                if (!rx_if.dout_valid || rx_if.dout_ready) begin
                    rx_if.dout       <= shreg;
                    rx_if.parity_err <= perr;
                    rx_if.frame_err  <= ferr;
                    rx_if.dout_valid <= 1'b1;
                end else begin
                    rx_if.overrun <= 1'b1;
                end
            end
        end
    end

endmodule
